// File: rtl/fft_out_reorder.sv
// fft_out_reorder: reorders the FFT core's bit-reversed output frames into
// natural index order using a two-bank ping-pong buffer, and re-emits them
// over a valid/ready handshake with a last-sample marker.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_data   sample stream from the FFT core (bit-reversed order)
//   in_ready           write bank can accept a sample (combinational)
//   out_valid/out_data natural-order sample stream to the sink
//   out_last           marks the sample at index N-1
//   out_ready          sink accepts out_data
//   err_overflow       sticky: a sample was offered while in_ready was low
//   out_mag            re*re + im*im of out_data (only with FFT_OUT_MAG_EN)
//
// Build option: define FFT_OUT_MAG_EN to add the out_mag output.

module fft_out_reorder #(
    parameter int unsigned DW    = 34,
    parameter int unsigned LOG2N = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
`ifdef FFT_OUT_MAG_EN
    output logic [DW-1:0] out_mag,
`endif
    output logic          err_overflow
);

    localparam int unsigned N  = 1 << LOG2N;
    localparam int unsigned HW = DW / 2;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Bit-reverse a frame index.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = a[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    logic [DW-1:0]    r_mem [2][N];

    logic             r_wr_bank;
    logic [LOG2N-1:0] r_wr_cnt;
    logic             r_rd_bank;
    logic [LOG2N-1:0] r_rd_cnt;
    logic [1:0]       r_full;
    logic             r_err;
    state_t           r_state;
    logic             r_out_valid;
    logic             r_out_last;
    logic [DW-1:0]    r_out_data;

    logic             w_in_ready;
    logic             w_wr_en;
    logic             w_wr_last;
    logic             w_load;
    logic             w_rd_last;
    logic             w_rd_free;
    logic [1:0]       w_full_nxt;
    logic [DW-1:0]    w_rd_data;
    state_t           w_state_nxt;
    logic             w_out_valid_nxt;
    logic             w_out_last_nxt;
    logic             w_rd_bank_nxt;
    logic [LOG2N-1:0] w_rd_cnt_nxt;

    assign w_in_ready = ~r_full[r_wr_bank];
    assign w_wr_en    = in_valid & w_in_ready;
    assign w_wr_last  = (r_wr_cnt == LOG2N'(N - 1));
    assign w_rd_last  = (r_rd_cnt == LOG2N'(N - 1));
    assign w_load     = r_full[r_rd_bank] & (~r_out_valid | out_ready);
    assign w_rd_data  = r_mem[r_rd_bank][r_rd_cnt];

    // Buffer storage: write in bit-reversed position so reads run linearly.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][bitrev(r_wr_cnt)] <= in_data;
        end
    end

    // Full flags: a fill and a free in the same cycle always target different banks.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_en && w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_free) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Write side: counter, bank select, overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_full    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + LOG2N'(1);
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (in_valid && !w_in_ready) begin
                r_err <= 1'b1;
            end
        end
    end

    // Read FSM next-state and output-register next values.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_rd_bank_nxt   = r_rd_bank;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_rd_free       = 1'b0;

        if (w_load) begin
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = w_rd_last;
            w_rd_cnt_nxt    = r_rd_cnt + LOG2N'(1);
            if (w_rd_last) begin
                w_rd_bank_nxt = ~r_rd_bank;
                w_rd_free     = 1'b1;
            end
        end else if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                // Stay streaming if the other bank is (or is becoming) full.
                if (w_load && w_rd_last) begin
                    w_state_nxt = w_full_nxt[~r_rd_bank] ? STREAM : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read side registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            if (w_load) begin
                r_out_data <= w_rd_data;
            end
        end
    end

`ifdef FFT_OUT_MAG_EN
    logic signed [HW-1:0]   w_re;
    logic signed [HW-1:0]   w_im;
    logic signed [2*HW-1:0] w_re_sq;
    logic signed [2*HW-1:0] w_im_sq;
    logic [DW-1:0]          w_mag;
    logic [DW-1:0]          r_out_mag;

    // Squares are non-negative, so summing them unsigned at full width is exact.
    assign w_re    = w_rd_data[DW-1:HW];
    assign w_im    = w_rd_data[HW-1:0];
    assign w_re_sq = w_re * w_re;
    assign w_im_sq = w_im * w_im;
    assign w_mag   = DW'($unsigned(w_re_sq)) + DW'($unsigned(w_im_sq));

    // Magnitude register follows the same load/hold rule as out_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_mag <= '0;
        end else if (w_load) begin
            r_out_mag <= w_mag;
        end
    end

    assign out_mag = r_out_mag;
`endif

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign err_overflow = r_err;

endmodule
